bus_ctrl: RTL and testbench
===========================

BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- NREG, 4: number of decoded regions.
- AW, 16: address width.
- DIV, 27: clk cycles per CPU cycle, with DIV >= 1.
- BASE, {16'h0000,16'h0000,16'h0000,16'h1000}: NREG*AW concatenated base addresses, region i at bits [i*AW +: AW].
- MASK, {16'h0000,16'h0000,16'h0000,16'hF000}: NREG*AW concatenated match masks, where MASK_i = 0 disables region i.
- WAIT, 16'h0000: NREG*4 concatenated wait states per region, each 0..15.
- OPEN_BUS, 8'hEA: read data returned for unmapped accesses.
- RST_CYC, 2: cpu_ce pulses cpu_reset is held after reset falls, with RST_CYC >= 1.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: single system clock.
- reset, in, 1: synchronous, active-high reset.
- cpu_ab, in, AW: CPU address bus.
- cpu_we, in, 1: CPU write enable, active high.
- cpu_di, out, 8: read data to the CPU.
- cpu_ce, out, 1: CPU clock enable.
- cpu_rdy, out, 1: CPU ready.
- cpu_reset, out, 1: CPU reset, active high.
- sel, out, NREG: one-hot region select, combinational from cpu_ab.
- wr_stb, out, NREG: one-clk write strobe per region.
- rd_data, in, NREG*8: region read data, region i at [i*8 +: 8].
- bus_err, out, 1: sticky unmapped-access flag.
- err_addr, out, AW: address of the first unmapped access.
- err_clr, in, 1: clears bus_err.

Function
REQ-003 SHALL run a divider counter 0..DIV-1 and assert cpu_ce for exactly one clk when the count equals DIV-1; with DIV=1, cpu_ce SHALL be constantly high outside reset.
REQ-004 SHALL decode region i as hit when (cpu_ab & MASK_i) == (BASE_i & MASK_i) and MASK_i != 0.
- The lowest-index hit SHALL win.
- sel SHALL be the priority-resolved one-hot vector.
- sel SHALL be all-zero when no region hits ("unmapped").
REQ-005 SHALL implement a wait FSM with states IDLE, WAIT and DONE, using a 4-bit counter cnt. W denotes WAIT of the hit region; W = 0 when unmapped.
REQ-006 In IDLE:
- cpu_rdy SHALL equal (W == 0).
- On cpu_ce with W == 1, the FSM SHALL go to DONE.
- On cpu_ce with W >= 2, the FSM SHALL go to WAIT and load cnt = W-2.
- Otherwise the FSM SHALL stay in IDLE.
REQ-007 In WAIT, cpu_rdy SHALL be 0; on cpu_ce, the FSM SHALL go to DONE if cnt == 0, else decrement cnt.
REQ-008 In DONE, cpu_rdy SHALL be 1; on cpu_ce, the FSM SHALL go to IDLE.
REQ-009 An access SHALL complete on the cpu_ce pulse where cpu_rdy == 1. cpu_rdy SHALL be low for exactly W consecutive CPU cycles before completion.
REQ-010 On completion, the block SHALL latch the hit region index, or an unmapped marker, into sel_q.
- cpu_di SHALL be rd_data[sel_q] when sel_q is a region, or OPEN_BUS when sel_q is unmapped.
- This gives one CPU cycle of read latency, suited to synchronous ROM.
- cpu_di SHALL hold its value between completions.
REQ-011 wr_stb[i] SHALL pulse for the single clk of completion when cpu_we == 1, region i hits and cpu_reset == 0. No strobe SHALL issue for unmapped writes.
REQ-012 A completion while unmapped and cpu_reset == 0 SHALL set bus_err.
- err_addr SHALL be captured only when bus_err was 0.
- err_clr SHALL clear bus_err.
- If err_clr and a new unmapped completion occur in the same clk, the set SHALL win and err_addr SHALL be recaptured.
REQ-013 cpu_ab changing while the FSM is in WAIT or DONE SHALL NOT reload cnt. The held address is the CPU's responsibility.

Reset
REQ-014 While reset is high, on each clk:
- divider counter = 0 and cpu_ce = 0;
- FSM = IDLE and cnt = 0;
- sel_q = unmapped, so cpu_di = OPEN_BUS;
- wr_stb = 0;
- bus_err = 0 and err_addr = 0;
- cpu_reset = 1.
REQ-015 After reset falls:
- cpu_ce SHALL resume pulsing.
- cpu_reset SHALL remain 1 until RST_CYC cpu_ce pulses have occurred, then go 0 in the clk after the last of those pulses.
- The wait FSM SHALL operate normally during cpu_reset.
REQ-016 Reset asserted mid-WAIT SHALL force IDLE on the next clk and discard the pending access. No strobe and no error SHALL result.

Verification
REQ-017 With DIV=4 and RST_CYC=2: pulse reset for 3 clk -> cpu_ce high on clks 4, 8, 12 after release, cpu_reset falls after the 2nd pulse, cpu_di = 8'hEA throughout.
REQ-018 With default regions and W=0: read 16'h1234 with rd_data[0] = 8'h5A -> cpu_rdy stays 1, and cpu_di = 8'h5A from the completion clk until the next completion.
REQ-019 With WAIT region0 = 3: access 16'h1000 -> cpu_rdy low for exactly 3 cpu_ce periods, then high for 1 period; exactly one completion.
REQ-020 With region0 MASK = 16'hF000 and BASE = 16'h1000, other regions disabled: write to 16'h0080 -> no wr_stb, bus_err = 1, err_addr = 16'h0080. A second unmapped access to 16'h0090 leaves err_addr = 16'h0080. err_clr together with a third unmapped access to 16'h00A0 gives bus_err = 1 and err_addr = 16'h00A0.
REQ-021 With overlapping regions 0 and 1 both matching 16'h1F00: write -> wr_stb = 4'b0001 for one clk; then raise reset during a 5-wait access -> cpu_rdy = 1 next clk and no strobe.

Source files
------------

// File: rtl/bus_ctrl.sv
// ---------------------------------------------------------------------------
// bus_ctrl
//   CPU bus controller: clock-enable divider, priority address decoder,
//   per-region wait-state FSM, read-data return mux, per-region write
//   strobes, sticky unmapped-access error capture and a CPU reset stretcher.
//
// Ports
//   clk        in   1        system clock
//   reset      in   1        synchronous active-high reset
//   cpu_ab     in   AW       CPU address bus
//   cpu_we     in   1        CPU write enable
//   cpu_di     out  8        read data to the CPU (OPEN_BUS when unmapped)
//   cpu_ce     out  1        CPU clock enable, one clk every DIV clks
//   cpu_rdy    out  1        CPU ready
//   cpu_reset  out  1        CPU reset, held for RST_CYC cpu_ce pulses
//   sel        out  NREG     one-hot region select (combinational)
//   wr_stb     out  NREG     one-clk write strobe per region
//   rd_data    in   NREG*8   region read data, region i at [i*8 +: 8]
//   bus_err    out  1        sticky unmapped-access flag
//   err_addr   out  AW       address of first unmapped access
//   err_clr    in   1        clears bus_err
// ---------------------------------------------------------------------------
module bus_ctrl #(
  parameter int                   NREG     = 4,
  parameter int                   AW       = 16,
  parameter int                   DIV      = 27,
  parameter logic [NREG*AW-1:0]   BASE     = {16'h0000, 16'h0000, 16'h0000, 16'h1000},
  parameter logic [NREG*AW-1:0]   MASK     = {16'h0000, 16'h0000, 16'h0000, 16'hF000},
  parameter logic [NREG*4-1:0]    WAIT     = 16'h0000,
  parameter logic [7:0]           OPEN_BUS = 8'hEA,
  parameter int                   RST_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     cpu_ab,
  input  logic              cpu_we,
  output logic [7:0]        cpu_di,
  output logic              cpu_ce,
  output logic              cpu_rdy,
  output logic              cpu_reset,
  output logic [NREG-1:0]   sel,
  output logic [NREG-1:0]   wr_stb,
  input  logic [NREG*8-1:0] rd_data,
  output logic              bus_err,
  output logic [AW-1:0]     err_addr,
  input  logic              err_clr
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW = $clog2(RST_CYC + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // divider
  logic [DW-1:0] div_q, div_d;
  logic          ce_q, ce_d;
  // decoder
  logic [NREG-1:0] sel_s;
  logic            hit_s;
  logic [IW-1:0]   hit_idx_s;
  logic [3:0]      w_s;
  // wait FSM
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rdy_s;
  logic       complete_s;
  // held in reset last clk: the CPU sees ready while the block is reset
  logic       in_rst_q;
  // completion / error / reset-stretch state
  logic          sel_vld_q, sel_vld_d;
  logic [IW-1:0] sel_idx_q, sel_idx_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          bus_err_q, bus_err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  // Divider next state; cpu_ce is registered so it lines up with count DIV-1.
  always_comb begin
    div_d = div_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
    ce_d = (div_d == DIV_LAST);
  end

  // Priority address decode: lowest-index enabled region that matches wins.
  always_comb begin
    sel_s     = '0;
    hit_s     = 1'b0;
    hit_idx_s = '0;
    w_s       = 4'd0;
    for (int i = 0; i < NREG; i++) begin
      if (!hit_s && (MASK[i*AW +: AW] != '0) &&
          ((cpu_ab & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW]))) begin
        hit_s     = 1'b1;
        hit_idx_s = IW'(i);
        sel_s[i]  = 1'b1;
        w_s       = WAIT[i*4 +: 4];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Wait-state FSM next state and ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy_s = (w_s == 4'd0);
        if (ce_q && (w_s == 4'd1)) begin
          state_d = S_DONE;
        end else if (ce_q && (w_s >= 4'd2)) begin
          state_d = S_WAIT;
          cnt_d   = w_s - 4'd2;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        rdy_s = 1'b0;
        if (ce_q && (cnt_q == 4'd0)) begin
          state_d = S_DONE;
        end else if (ce_q) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DONE: begin
        rdy_s = 1'b1;
        if (ce_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Completion side effects: return-data select, error capture, reset stretch.
  // A completion in the clk that reset rises is suppressed so the pending
  // access is discarded cleanly.
  always_comb begin
    complete_s  = ce_q & rdy_s & ~reset;
    sel_vld_d   = sel_vld_q;
    sel_idx_d   = sel_idx_q;
    bus_err_d   = bus_err_q;
    err_addr_d  = err_addr_q;
    rst_cnt_d   = rst_cnt_q;
    cpu_reset_d = cpu_reset_q;

    if (complete_s) begin
      sel_vld_d = hit_s;
      sel_idx_d = hit_idx_s;
    end else begin
      sel_vld_d = sel_vld_q;
    end

    // A new unmapped completion beats err_clr and recaptures the address.
    if (complete_s && !hit_s && !cpu_reset_q) begin
      bus_err_d = 1'b1;
      if (!bus_err_q || err_clr) begin
        err_addr_d = cpu_ab;
      end else begin
        err_addr_d = err_addr_q;
      end
    end else if (err_clr) begin
      bus_err_d = 1'b0;
    end else begin
      bus_err_d = bus_err_q;
    end

    if (cpu_reset_q && ce_q) begin
      if (rst_cnt_q == RST_LAST) begin
        cpu_reset_d = 1'b0;
      end else begin
        rst_cnt_d = rst_cnt_q + RW'(1);
      end
    end else begin
      cpu_reset_d = cpu_reset_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      ce_q        <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      in_rst_q    <= 1'b1;
      sel_vld_q   <= 1'b0;
      sel_idx_q   <= '0;
      rst_cnt_q   <= '0;
      cpu_reset_q <= 1'b1;
      bus_err_q   <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      div_q       <= div_d;
      ce_q        <= ce_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_rst_q    <= 1'b0;
      sel_vld_q   <= sel_vld_d;
      sel_idx_q   <= sel_idx_d;
      rst_cnt_q   <= rst_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      bus_err_q   <= bus_err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Read return: data of the region latched at the last completion.
  always_comb begin
    if (sel_vld_q) begin
      cpu_di = rd_data[{sel_idx_q, 3'b000} +: 8];
    end else begin
      cpu_di = OPEN_BUS;
    end
  end

  assign cpu_ce    = ce_q;
  assign cpu_rdy   = in_rst_q | rdy_s;
  assign cpu_reset = cpu_reset_q;
  assign sel       = sel_s;
  assign wr_stb    = (complete_s && cpu_we && !cpu_reset_q) ? sel_s : '0;
  assign bus_err   = bus_err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_ctrl.sv
module tb_bus_ctrl;

  localparam int DIV     = 4;
  localparam int RST_CYC = 2;
  localparam logic [63:0] P_BASE = {16'h4000, 16'h2000, 16'h1F00, 16'h1000};
  localparam logic [63:0] P_MASK = {16'hC000, 16'hF000, 16'hFF00, 16'hF000};
  localparam logic [15:0] P_WAIT = 16'h0503;

  // Region table as seen by the model
  logic [15:0] r_base [4] = '{16'h1000, 16'h1F00, 16'h2000, 16'h4000};
  logic [15:0] r_mask [4] = '{16'hF000, 16'hFF00, 16'hF000, 16'hC000};
  int          r_wait [4] = '{3, 0, 5, 0};

  logic        clk = 1'b0;
  logic        reset, cpu_we, err_clr;
  logic [15:0] cpu_ab;
  logic [31:0] rd_data;
  logic [7:0]  cpu_di;
  logic        cpu_ce, cpu_rdy, cpu_reset, bus_err;
  logic [3:0]  sel, wr_stb;
  logic [15:0] err_addr;

  int n_checks = 0;
  int n_fail   = 0;

  bus_ctrl #(
    .NREG(4), .AW(16), .DIV(DIV), .BASE(P_BASE), .MASK(P_MASK),
    .WAIT(P_WAIT), .OPEN_BUS(8'hEA), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we),
    .cpu_di(cpu_di), .cpu_ce(cpu_ce), .cpu_rdy(cpu_rdy),
    .cpu_reset(cpu_reset), .sel(sel), .wr_stb(wr_stb), .rd_data(rd_data),
    .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_k = 0, m_pulses = 0, m_rem = 0, m_last = -1;
  bit          m_ce = 1'b0, m_in_rst = 1'b1, m_cpu_reset = 1'b1, m_busy = 1'b0, m_err = 1'b0;
  logic [15:0] m_err_addr = 16'h0000;

  int          e_region, e_w;
  bit          e_rdy, e_complete;
  logic [3:0]  e_sel, e_wr;
  logic [7:0]  e_di;

  function automatic int ref_region(input logic [15:0] a);
    for (int r = 0; r < 4; r++)
      if (r_mask[r] != 16'h0000 && ((a & r_mask[r]) == (r_base[r] & r_mask[r]))) return r;
    return -1;
  endfunction

  always_comb begin
    e_region   = ref_region(cpu_ab);
    e_sel      = (e_region >= 0) ? (4'b0001 << e_region) : 4'b0000;
    e_w        = (e_region >= 0) ? r_wait[e_region] : 0;
    e_rdy      = m_in_rst ? 1'b1 : (m_busy ? (m_rem == 0) : (e_w == 0));
    e_complete = m_ce && e_rdy && !reset;
    e_wr       = (e_complete && cpu_we && !m_cpu_reset) ? e_sel : 4'b0000;
    e_di       = (m_last < 0) ? 8'hEA : rd_data[m_last*8 +: 8];
  end

  // Advance one clk: update the model from pre-edge inputs, end on negedge.
  task automatic tick();
    int  reg_i;
    bit  comp;
    reg_i = ref_region(cpu_ab);
    comp  = e_complete;
    @(posedge clk);
    if (reset) begin
      m_k = 0; m_ce = 1'b0; m_in_rst = 1'b1; m_cpu_reset = 1'b1; m_pulses = 0;
      m_busy = 1'b0; m_rem = 0; m_last = -1; m_err = 1'b0; m_err_addr = 16'h0000;
    end else begin
      if (comp && reg_i < 0 && !m_cpu_reset) begin
        if (!m_err || err_clr) m_err_addr = cpu_ab;
        m_err = 1'b1;
      end else if (err_clr) m_err = 1'b0;
      if (comp) m_last = reg_i;
      if (m_ce) begin
        if (!m_busy) begin
          if (reg_i >= 0 && r_wait[reg_i] > 0) begin
            m_busy = 1'b1; m_rem = r_wait[reg_i] - 1;
          end
        end else if (m_rem == 0) m_busy = 1'b0;
        else m_rem = m_rem - 1;
      end
      if (m_cpu_reset && m_ce) begin
        m_pulses = m_pulses + 1;
        if (m_pulses == RST_CYC) m_cpu_reset = 1'b0;
      end
      m_k      = m_k + 1;
      m_ce     = ((m_k % DIV) == DIV - 1);
      m_in_rst = 1'b0;
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; cpu_ab = 16'h0080; cpu_we = 1'b0; err_clr = 1'b0; rd_data = $urandom;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      n_checks++; if (cpu_ce !== 1'b0)    begin n_fail++; $display("FAIL rst_ce got=%b exp=0", cpu_ce); end
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset got=%b exp=1", cpu_reset); end
      n_checks++; if (cpu_di !== 8'hEA)   begin n_fail++; $display("FAIL rst_di got=%h exp=ea", cpu_di); end
      n_checks++; if (bus_err !== 1'b0)   begin n_fail++; $display("FAIL rst_bus_err got=%b exp=0", bus_err); end
      n_checks++; if (err_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_err_addr got=%h exp=0000", err_addr); end
      n_checks++; if (wr_stb !== 4'b0000) begin n_fail++; $display("FAIL rst_wr_stb got=%b exp=0000", wr_stb); end
    end
    reset = 1'b0;
    for (int k = 0; k < 13; k++) begin
      #1;
      n_checks++; if (cpu_ce !== ((k % DIV) == DIV - 1))
        begin n_fail++; $display("FAIL rel_ce k=%0d got=%b exp=%b", k, cpu_ce, ((k % DIV) == DIV - 1)); end
      n_checks++; if (cpu_reset !== (k < 8))
        begin n_fail++; $display("FAIL rel_cpu_reset k=%0d got=%b exp=%b", k, cpu_reset, (k < 8)); end
      n_checks++; if (cpu_di !== 8'hEA) begin n_fail++; $display("FAIL rel_di k=%0d got=%h exp=ea", k, cpu_di); end
      tick();
    end
  endtask

  task automatic test_read_nowait();
    bit done = 1'b0;
    err_clr = 1'b1; cpu_ab = 16'h4234; cpu_we = 1'b0;
    rd_data = {8'h5A, 24'($urandom)};
    tick(); err_clr = 1'b0; #1;
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL clr_bus_err got=%b exp=0", bus_err); end
    for (int c = 0; c < 4 * DIV && !done; c++) begin
      #1;
      n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL w0_rdy got=%b exp=1", cpu_rdy); end
      n_checks++; if (sel !== 4'b1000)  begin n_fail++; $display("FAIL w0_sel got=%b exp=1000", sel); end
      done = e_complete;
      tick();
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL w0_timeout got=0 exp=1"); end
    for (int c = 0; c < DIV; c++) begin
      #1;
      n_checks++; if (cpu_di !== 8'h5A) begin n_fail++; $display("FAIL w0_di got=%h exp=5a", cpu_di); end
      tick();
    end
  endtask

  task automatic test_wait_states();
    int lows = 0, comps = 0;
    cpu_ab = 16'h1000; cpu_we = 1'b0; rd_data = $urandom;
    for (int c = 0; c < 10 * DIV && comps == 0; c++) begin
      #1;
      n_checks++; if (cpu_rdy !== e_rdy) begin n_fail++; $display("FAIL w3_rdy got=%b exp=%b", cpu_rdy, e_rdy); end
      if (cpu_ce && !cpu_rdy) lows++;
      if (cpu_ce && cpu_rdy) comps++;
      tick();
    end
    cpu_ab = 16'h8000;
    n_checks++; if (lows != 3)  begin n_fail++; $display("FAIL w3_low_periods got=%0d exp=3", lows); end
    n_checks++; if (comps != 1) begin n_fail++; $display("FAIL w3_completions got=%0d exp=1", comps); end
    #1;
    n_checks++; if (cpu_di !== rd_data[7:0]) begin n_fail++; $display("FAIL w3_di got=%h exp=%h", cpu_di, rd_data[7:0]); end
  endtask

  task automatic test_unmapped();
    logic [15:0] addrs [3] = '{16'h0080, 16'h0090, 16'h00A0};
    logic [15:0] exp_ea [3] = '{16'h0080, 16'h0080, 16'h00A0};
    bit done;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    for (int a = 0; a < 3; a++) begin
      done = 1'b0; cpu_ab = addrs[a]; cpu_we = (a == 0); err_clr = (a == 2);
      for (int c = 0; c < 4 * DIV && !done; c++) begin
        #1;
        n_checks++; if (wr_stb !== 4'b0000) begin n_fail++; $display("FAIL um_wr_stb got=%b exp=0000", wr_stb); end
        done = e_complete;
        tick();
      end
      err_clr = 1'b0; #1;
      n_checks++; if (!done) begin n_fail++; $display("FAIL um_timeout a=%0d got=0 exp=1", a); end
      n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL um_bus_err a=%0d got=%b exp=1", a, bus_err); end
      n_checks++; if (err_addr !== exp_ea[a])
        begin n_fail++; $display("FAIL um_err_addr a=%0d got=%h exp=%h", a, err_addr, exp_ea[a]); end
      n_checks++; if (cpu_di !== 8'hEA) begin n_fail++; $display("FAIL um_di got=%h exp=ea", cpu_di); end
    end
  endtask

  task automatic test_overlap_reset();
    bit done = 1'b0;
    int stbs = 0;
    cpu_ab = 16'h1F00; cpu_we = 1'b1;
    for (int c = 0; c < 10 * DIV && !done; c++) begin
      #1;
      if (wr_stb !== 4'b0000) stbs++;
      if (e_complete) begin
        done = 1'b1;
        n_checks++; if (wr_stb !== 4'b0001) begin n_fail++; $display("FAIL ov_wr_stb got=%b exp=0001", wr_stb); end
      end
      tick();
    end
    cpu_ab = 16'h2000; #1;
    if (wr_stb !== 4'b0000) stbs++;
    n_checks++; if (!done)     begin n_fail++; $display("FAIL ov_timeout got=0 exp=1"); end
    n_checks++; if (stbs != 1) begin n_fail++; $display("FAIL ov_stb_cycles got=%0d exp=1", stbs); end
    for (int c = 0; c < 10 * DIV && !(m_busy && m_rem <= 3); c++) begin
      #1;
      n_checks++; if (wr_stb !== 4'b0000) begin n_fail++; $display("FAIL w5_wr_stb got=%b exp=0000", wr_stb); end
      tick();
    end
    n_checks++; if (!(m_busy && m_rem <= 3)) begin n_fail++; $display("FAIL w5_timeout got=0 exp=1"); end
    reset = 1'b1; tick(); #1;
    n_checks++; if (cpu_rdy !== 1'b1)   begin n_fail++; $display("FAIL rs_rdy got=%b exp=1", cpu_rdy); end
    n_checks++; if (wr_stb !== 4'b0000) begin n_fail++; $display("FAIL rs_wr_stb got=%b exp=0000", wr_stb); end
    n_checks++; if (bus_err !== 1'b0)   begin n_fail++; $display("FAIL rs_bus_err got=%b exp=0", bus_err); end
    tick(); reset = 1'b0;
    for (int c = 0; c < 3 * DIV; c++) begin
      #1;
      n_checks++; if (wr_stb !== 4'b0000) begin n_fail++; $display("FAIL rs_post_stb got=%b exp=0000", wr_stb); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [35:0] got, exp;
    int r;
    for (int n = 0; n < 30; n++) begin
      bit done = 1'b0;
      r = $urandom_range(0, 4);
      if (r < 4) cpu_ab = (r_base[r] & r_mask[r]) | (16'($urandom) & ~r_mask[r]);
      else       cpu_ab = {1'b1, 15'($urandom)};
      cpu_we = $urandom_range(0, 1); rd_data = $urandom;
      for (int c = 0; c < 10 * DIV && !done; c++) begin
        err_clr = ($urandom_range(0, 7) == 0);
        #1;
        got = {cpu_rdy, sel, wr_stb, cpu_di, bus_err, err_addr, cpu_ce, cpu_reset};
        exp = {e_rdy, e_sel, e_wr, e_di, m_err, m_err_addr, m_ce, m_cpu_reset};
        n_checks++; if (got !== exp)
          begin n_fail++; $display("FAIL rnd_outputs n=%0d addr=%h got=%h exp=%h", n, cpu_ab, got, exp); end
        done = e_complete;
        tick();
      end
      err_clr = 1'b0;
      n_checks++; if (!done) begin n_fail++; $display("FAIL rnd_timeout n=%0d got=0 exp=1", n); end
    end
  endtask

  initial begin
    test_reset();
    test_read_nowait();
    test_wait_states();
    test_unmapped();
    test_overlap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
